// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for a picorv32-style native memory bus.
// Latency: one arbitration cycle in IDLE, then request/response pass straight
//   through combinationally while a requester owns the bus.
// Backpressure: one transaction outstanding; the losing requester waits with
//   ready low, and a watchdog ends stalled slave accesses with an error reply.
//
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   m0_* / m1_*           - requester buses (valid, addr, wdata, wstrb -> rdata, ready)
//   s_*                   - slave bus towards the memory / MMIO decode block
//   grant                 - one-hot current owner, 00 when idle
//   timeout_err           - one-cycle pulse when the watchdog terminates an access
module mem_bus_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF,
  parameter int          CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        s_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY0 = 2'd1;
  localparam logic [1:0] BUSY1 = 2'd2;

  // Watchdog value at which the access is terminated; unused when TIMEOUT is 0.
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WD_MAX  = '1;
  localparam logic             WD_ON   = (TIMEOUT != 0);

  logic [1:0]       state, state_nxt;
  logic             last, last_nxt;
  logic [CNT_W-1:0] wd;

  logic        busy;
  logic        own1;
  logic        cur_valid;
  logic        expire;
  logic        resp_ready;
  logic [31:0] resp_data;

  // Outputs are gated by reset so nothing leaks out during the reset cycle,
  // even if the state register still holds a busy state.
  assign busy      = !reset && (state == BUSY0 || state == BUSY1);
  assign own1      = (state == BUSY1);
  assign cur_valid = own1 ? m1_valid : m0_valid;
  // s_ready in the expiry cycle wins: the access completes normally.
  assign expire    = busy && WD_ON && cur_valid && !s_ready && (wd == WD_LAST);

  assign resp_ready = s_ready || expire;
  assign resp_data  = expire ? ERR_DATA : s_rdata;

  always_comb begin
    s_valid     = 1'b0;
    s_addr      = '0;
    s_wdata     = '0;
    s_wstrb     = '0;
    m0_ready    = 1'b0;
    m0_rdata    = '0;
    m1_ready    = 1'b0;
    m1_rdata    = '0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    if (busy) begin
      s_valid     = cur_valid && !expire;
      s_addr      = own1 ? m1_addr  : m0_addr;
      s_wdata     = own1 ? m1_wdata : m0_wdata;
      s_wstrb     = own1 ? m1_wstrb : m0_wstrb;
      timeout_err = expire;
      if (own1) begin
        grant    = 2'b10;
        m1_ready = resp_ready;
        m1_rdata = resp_data;
      end else begin
        grant    = 2'b01;
        m0_ready = resp_ready;
        m0_rdata = resp_data;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (m0_valid && (!m1_valid || last)) begin
          state_nxt = BUSY0;
        end else if (m1_valid) begin
          state_nxt = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        if (s_ready || expire) begin
          state_nxt = IDLE;
          last_nxt  = own1;
        end else if (!cur_valid) begin
          // Requester withdrew without a response: abandon, fairness untouched.
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      last  <= 1'b1;
      wd    <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      // Held at zero while idle so every access starts counting from zero;
      // saturates rather than wrapping when the watchdog is disabled.
      if (state == IDLE || state_nxt == IDLE) begin
        wd <= '0;
      end else if (wd != WD_MAX) begin
        wd <= wd + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_valid = 1'b0, m1_valid = 1'b0;
  logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic [31:0] s_rdata = '0;
  logic        s_ready = 1'b0;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_bus_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  rsp_t e;
  int   vectors = 0;
  int   miscompares = 0;
  int   got_port;
  int   sv_cnt;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
    m0_addr = 32'h55; m1_addr = 32'h66;
    next_cycle();
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({grant, s_valid, m0_ready, m1_ready, timeout_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: grant=%b s_valid=%b m0_ready=%b m1_ready=%b terr=%b, required all 0",
               grant, s_valid, m0_ready, m1_ready, timeout_err);
    end
    next_cycle();
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({grant, s_valid, s_addr} !== 35'b0) begin
      miscompares++;
      $display("FAIL reset_idle: grant=%b s_valid=%b s_addr=%h, required 00/0/0", grant, s_valid, s_addr);
    end
  endtask

  task automatic test_single_read();
    sb.push_back('{0, 32'h1234_5678, 1'b0});
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      m0_valid = (c <= 3); m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000;
      m1_addr = 32'h9999_0000;
      s_ready = (c == 3);
      s_rdata = (c == 3) ? 32'h1234_5678 : 32'h0BAD_0BAD;
      @(negedge clk);
      vectors++;
      if (grant !== ((c >= 1 && c <= 3) ? 2'b01 : 2'b00)) begin
        miscompares++;
        $display("FAIL read_grant c%0d: grant=%b", c, grant);
      end
      vectors++;
      if ({m1_ready, m1_rdata} !== 33'b0 || m0_ready !== (c == 3)) begin
        miscompares++;
        $display("FAIL read_ready c%0d: m0_ready=%b m1_ready=%b m1_rdata=%h", c, m0_ready, m1_ready, m1_rdata);
      end
      vectors++;
      if (s_valid !== (c >= 1 && c <= 3) || s_addr !== ((c >= 1 && c <= 3) ? 32'h10 : 32'h0)) begin
        miscompares++;
        $display("FAIL read_slave c%0d: s_valid=%b s_addr=%h", c, s_valid, s_addr);
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL read_sb: unexpected ready on m%0d, no response pending", got_port);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data || timeout_err !== e.err) begin
            miscompares++;
            $display("FAIL read_sb: got m%0d data=%h err=%b, required m%0d data=%h err=%b",
                     got_port, got_port ? m1_rdata : m0_rdata, timeout_err, e.port, e.data, e.err);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL read_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_alternation();
    do_reset();
    for (int i = 0; i < 4; i++) sb.push_back('{i % 2, 32'hA000_0000 + 32'(2 * i + 1), 1'b0});
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      m0_valid = 1'b1; m0_addr = 32'h100;
      m1_valid = 1'b1; m1_addr = 32'h200;
      s_ready = 1'b1; s_rdata = 32'hA000_0000 + 32'(c);
      @(negedge clk);
      vectors++;
      if (grant !== ((c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10))) begin
        miscompares++;
        $display("FAIL alt_grant c%0d: grant=%b", c, grant);
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0 || (m0_ready && m1_ready)) begin
          miscompares++;
          $display("FAIL alt_sb: unexpected ready m0=%b m1=%b", m0_ready, m1_ready);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data) begin
            miscompares++;
            $display("FAIL alt_sb: got m%0d data=%h, required m%0d data=%h",
                     got_port, got_port ? m1_rdata : m0_rdata, e.port, e.data);
          end
        end
      end
    end
    next_cycle();
    idle_inputs();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL alt_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_timeout();
    sv_cnt = 0;
    sb.push_back('{1, 32'hDEAD_BEEF, 1'b1});
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      m1_valid = (c <= 4); m1_addr = 32'h1000_0000; m1_wdata = 32'h41; m1_wstrb = 4'b0001;
      s_ready = 1'b0; s_rdata = 32'h7777_7777;
      @(negedge clk);
      if (s_valid) sv_cnt++;
      vectors++;
      if (grant !== ((c >= 1 && c <= 4) ? 2'b10 : 2'b00) || timeout_err !== (c == 4)) begin
        miscompares++;
        $display("FAIL to_grant c%0d: grant=%b terr=%b", c, grant, timeout_err);
      end
      if (c >= 1 && c <= 3) begin
        vectors++;
        if ({s_valid, s_addr, s_wdata, s_wstrb} !== {1'b1, 32'h1000_0000, 32'h41, 4'b0001}) begin
          miscompares++;
          $display("FAIL to_slave c%0d: s_valid=%b addr=%h wdata=%h wstrb=%b", c, s_valid, s_addr, s_wdata, s_wstrb);
        end
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL to_sb: unexpected ready on m%0d", got_port);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data || timeout_err !== e.err || c != 4) begin
            miscompares++;
            $display("FAIL to_sb c%0d: got m%0d data=%h err=%b, required m%0d data=%h err=%b at c4",
                     c, got_port, got_port ? m1_rdata : m0_rdata, timeout_err, e.port, e.data, e.err);
          end
        end
      end
    end
    vectors++;
    if (sv_cnt != 3 || sb.size() != 0) begin
      miscompares++;
      $display("FAIL to_count: s_valid cycles=%0d pending=%0d, required 3 and 0", sv_cnt, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_ready_at_expiry();
    sb.push_back('{0, 32'h5555_AAAA, 1'b0});
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      m1_valid = 1'b0;
      m0_valid = (c <= 4); m0_addr = 32'h20; m0_wstrb = 4'b0000;
      s_ready = (c == 4); s_rdata = (c == 4) ? 32'h5555_AAAA : 32'h0;
      @(negedge clk);
      vectors++;
      if (timeout_err !== 1'b0 || grant !== ((c >= 1 && c <= 4) ? 2'b01 : 2'b00) ||
          s_valid !== (c >= 1 && c <= 4)) begin
        miscompares++;
        $display("FAIL exp_tie c%0d: terr=%b grant=%b s_valid=%b", c, timeout_err, grant, s_valid);
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL exp_sb: unexpected ready on m%0d", got_port);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data || c != 4) begin
            miscompares++;
            $display("FAIL exp_sb c%0d: got m%0d data=%h, required m%0d data=%h at c4",
                     c, got_port, got_port ? m1_rdata : m0_rdata, e.port, e.data);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL exp_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset_midtxn();
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      reset = (c == 3);
      m0_valid = (c <= 3) || (c == 5) || (c == 6); m0_addr = 32'h30;
      m1_valid = (c == 5); m1_addr = 32'h40;
      s_ready = (c == 6); s_rdata = (c == 6) ? 32'h3C3C_3C3C : 32'h0;
      if (c == 5) sb.push_back('{0, 32'h3C3C_3C3C, 1'b0});
      @(negedge clk);
      vectors++;
      if (grant !== ((c == 1 || c == 2 || c == 6) ? 2'b01 : 2'b00) ||
          s_valid !== (c == 1 || c == 2 || c == 6)) begin
        miscompares++;
        $display("FAIL rst_mid c%0d: grant=%b s_valid=%b", c, grant, s_valid);
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rst_sb c%0d: unexpected ready on m%0d", c, got_port);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data) begin
            miscompares++;
            $display("FAIL rst_sb c%0d: got m%0d data=%h, required m%0d data=%h",
                     c, got_port, got_port ? m1_rdata : m0_rdata, e.port, e.data);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL rst_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_drop();
    sb.push_back('{1, 32'h1111_1111, 1'b0});
    sb.push_back('{0, 32'h2222_2222, 1'b0});
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      m1_valid = (c == 0 || c == 1 || c == 3 || c == 4); m1_addr = 32'h50;
      m0_valid = (c >= 1 && c <= 6); m0_addr = 32'h60;
      s_ready = (c == 4 || c == 6);
      s_rdata = (c == 4) ? 32'h1111_1111 : (c == 6) ? 32'h2222_2222 : 32'h0;
      @(negedge clk);
      vectors++;
      if (grant !== ((c == 1 || c == 2 || c == 4) ? 2'b10 : (c == 6) ? 2'b01 : 2'b00) ||
          s_valid !== (c == 1 || c == 4 || c == 6)) begin
        miscompares++;
        $display("FAIL drop_grant c%0d: grant=%b s_valid=%b", c, grant, s_valid);
      end
      if (c == 4) begin
        vectors++;
        if ({m0_ready, m0_rdata} !== 33'b0) begin
          miscompares++;
          $display("FAIL drop_loser: m0_ready=%b m0_rdata=%h, required 0/0", m0_ready, m0_rdata);
        end
      end
      if (m0_ready || m1_ready) begin
        vectors++;
        got_port = m1_ready ? 1 : 0;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL drop_sb c%0d: unexpected ready on m%0d", c, got_port);
        end else begin
          e = sb.pop_front();
          if (got_port != e.port || (got_port ? m1_rdata : m0_rdata) !== e.data) begin
            miscompares++;
            $display("FAIL drop_sb c%0d: got m%0d data=%h, required m%0d data=%h",
                     c, got_port, got_port ? m1_rdata : m0_rdata, e.port, e.data);
          end
        end
      end
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drop_missing: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_alternation();
    test_timeout();
    test_ready_at_expiry();
    test_reset_midtxn();
    test_drop();
    next_cycle();
    idle_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-requester round-robin arbiter for the single-port memory / MMIO bus driven by the picorv32 native interface (valid/ready, addr, wdata, wstrb, rdata).
- Requester 0 is the CPU core; requester 1 is a secondary bus master (display text fetcher or DMA).
- Sits between both masters and the memory/peripheral decode block, and guarantees exactly one outstanding transaction at a time.
- A watchdog timeout terminates hung slave accesses with an error response so no master stalls forever.

Parameters:
- TIMEOUT, 64: max slave-wait cycles per transaction; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the requester on timeout.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid  in  1  requester 0 transaction request.
- m0_addr  in  32  requester 0 byte address.
- m0_wdata  in  32  requester 0 write data.
- m0_wstrb  in  4  requester 0 byte strobes; 0 = read.
- m0_rdata  out  32  requester 0 read data.
- m0_ready  out  1  requester 0 completion pulse.
- m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready: same as m0, for requester 1.
- s_valid  out  1  slave request.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_rdata  in  32  slave read data.
- s_ready  in  1  slave completion.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- States: IDLE, BUSY0, BUSY1. Register `last` records the most recently served requester.
- Reset: state=IDLE, last=1 (so m0 wins the first tie), watchdog=0, grant=00, timeout_err=0. All ready/valid outputs are 0 in the reset cycle.
- Reset mid-transaction: abandons the access silently and returns no ready.
- IDLE:
  - Only m0_valid -> BUSY0. Only m1_valid -> BUSY1.
  - Both valid -> grant the requester != last.
  - Neither -> stay in IDLE.
  - No s_valid is asserted in IDLE. Arbitration always costs exactly one cycle.
- BUSYk:
  - s_valid = mk_valid. s_addr, s_wdata and s_wstrb mux combinationally from requester k. grant[k]=1.
  - mk_ready = s_ready and mk_rdata = s_rdata, combinational pass-through.
  - The non-granted requester sees ready=0 and rdata=0 regardless of slave activity.
- Completion: s_ready high while in BUSYk -> next state IDLE, last<=k, watchdog<=0.
  - Back-to-back requests therefore have one idle bubble between them.
  - Guarantees alternation under continuous contention.
- Requester drops mk_valid while in BUSYk without ready (protocol violation): next state IDLE, `last` unchanged, no ready issued.
- Watchdog:
  - Clears on entry to BUSYk and increments each BUSYk cycle without s_ready.
  - When watchdog == TIMEOUT-1 and s_ready=0 (TIMEOUT != 0): this cycle drives mk_ready=1, mk_rdata=ERR_DATA, s_valid=0, timeout_err=1. Next state IDLE, last<=k.
  - s_ready and expiry in the same cycle: s_ready wins, with normal data and no error.
  - Counter saturates and never wraps.
- Outputs when idle: s_addr, s_wdata, s_wstrb = 0 and s_valid = 0.
- Write strobes pass unmodified. The arbiter performs no address decode.

Test Plan:
- m0 read addr 0x0000_0010, slave ready after 2 cycles with rdata 0x1234_5678 -> grant=01 from cycle 1, m0_ready pulse with rdata 0x1234_5678 at cycle 3, m1_ready=0 throughout.
- m0 and m1 continuously valid, slave single-cycle ready -> grants alternate 01,10,01,10 with one idle cycle between each; m0 served first after reset.
- m1 write addr 0x1000_0000 wdata 0x41 wstrb 0001, slave never ready, TIMEOUT=4 -> s_valid high 3 cycles, then m1_ready=1, m1_rdata=0xDEAD_BEEF, timeout_err one cycle, grant=00 next cycle.
- s_ready asserted in exactly the expiry cycle (TIMEOUT=4) -> normal completion, timeout_err stays 0.
- reset asserted while in BUSY0 with slave stalled -> next cycle grant=00, s_valid=0, m0_ready never pulses; the first request after release goes to m0 on a tie.
- m1 deasserts valid mid-transaction while m0 pending -> arbiter returns to IDLE, then grants m0 (last still 0 -> m1 would win a tie; verify m1 granted if it re-requests simultaneously).
